// File: rtl/openram_pkg.sv
// Shared definitions for the OpenRAM test-chip scan loader: default widths,
// input FSM state encoding and command packet field offsets.
package openram_pkg;

  localparam int PKT_W_DEF = 112;
  localparam int OUT_W_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHIFT    = 2'd1,
    ST_VALID    = 2'd2,
    ST_WAIT_LOW = 2'd3
  } scan_state_e;

  // Packet layout, MSB first: sram select, then port 0, then port 1.
  localparam int SRAM_SEL_HI  = 111;
  localparam int SRAM_SEL_LO  = 108;
  localparam int P0_ADDR_HI   = 107;
  localparam int P0_ADDR_LO   = 92;
  localparam int P0_DATA_HI   = 91;
  localparam int P0_DATA_LO   = 60;
  localparam int P0_CSB       = 59;
  localparam int P0_WEB       = 58;
  localparam int P0_WMASK_HI  = 57;
  localparam int P0_WMASK_LO  = 54;
  localparam int P1_ADDR_HI   = 53;
  localparam int P1_ADDR_LO   = 38;
  localparam int P1_DATA_HI   = 37;
  localparam int P1_DATA_LO   = 6;
  localparam int P1_CSB       = 5;
  localparam int P1_WEB       = 4;
  localparam int P1_WMASK_HI  = 3;
  localparam int P1_WMASK_LO  = 0;

endpackage

// File: rtl/openram_scan_out.sv
// Read-result serializer: loads on rd_valid, presents MSB first, one bit per
// cycle for OUT_W cycles. A new rd_valid restarts the shift-out.
module openram_scan_out #(
  parameter int OUT_W = 64
) (
  input  logic             gpio_clk,
  input  logic             reset,
  input  logic [OUT_W-1:0] rd_data,
  input  logic             rd_valid,
  output logic             out_bit,
  output logic             out_active
);

  localparam int CNT_W = $clog2(OUT_W + 1);

  logic [OUT_W-1:0] sreg;
  logic [CNT_W-1:0] remain;

  // Load / shift register with remaining-bit counter; latest rd_valid wins.
  always_ff @(posedge gpio_clk or negedge reset) begin
    if (!reset) begin
      sreg       <= '0;
      remain     <= '0;
      out_active <= 1'b0;
    end else if (rd_valid) begin
      sreg       <= rd_data;
      remain     <= CNT_W'(OUT_W);
      out_active <= 1'b1;
    end else if (out_active) begin
      sreg   <= {sreg[OUT_W-2:0], 1'b0};
      remain <= remain - CNT_W'(1);
      if (remain == CNT_W'(1)) out_active <= 1'b0;
    end
  end

  assign out_bit = sreg[OUT_W-1];

endmodule

// File: rtl/openram_scan_loader.sv
// Serial command-packet loader for the OpenRAM test chip plus read-result
// serializer. Define SCAN_PARITY_EN to append an even-parity bit to each frame.
module openram_scan_loader
  import openram_pkg::*;
#(
  parameter int PKT_W = PKT_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic             gpio_clk,
  input  logic             reset,
  input  logic             scan_en,
  input  logic             scan_bit,
  output logic [PKT_W-1:0] pkt_data,
  output logic             pkt_valid,
  input  logic             pkt_ready,
  input  logic [OUT_W-1:0] rd_data,
  input  logic             rd_valid,
  output logic             out_bit,
  output logic             out_active,
  output logic             busy,
  output logic             err,
  output logic [7:0]       pkt_count
);

`ifdef SCAN_PARITY_EN
  localparam int FRAME_W = PKT_W + 1;
`else
  localparam int FRAME_W = PKT_W;
`endif
  // Holds every frame bit except the one arriving on the closing edge.
  localparam int SH_W  = FRAME_W - 1;
  localparam int CNT_W = $clog2(FRAME_W + 1);

  scan_state_e      state, state_nxt;
  logic [SH_W-1:0]  shreg;
  logic [SH_W-1:0]  shift_in;
  logic [CNT_W-1:0] bit_cnt;
  logic [PKT_W-1:0] frame_word;
  logic             frame_ok;
  logic             last_bit;
  logic             take_first, take_bit, load_pkt, frame_err, accept;

  assign shift_in = {shreg[SH_W-2:0], scan_bit};
  assign last_bit = (bit_cnt == CNT_W'(FRAME_W - 1));

`ifdef SCAN_PARITY_EN
  // Closing bit is parity; data is already fully in the shift register.
  assign frame_word = shreg;
  assign frame_ok   = ~(^shreg ^ scan_bit);
`else
  assign frame_word = {shreg, scan_bit};
  assign frame_ok   = 1'b1;
`endif

  // State register.
  always_ff @(posedge gpio_clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and datapath strobes.
  always_comb begin
    state_nxt  = state;
    take_first = 1'b0;
    take_bit   = 1'b0;
    load_pkt   = 1'b0;
    frame_err  = 1'b0;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (scan_en) begin
          state_nxt  = ST_SHIFT;
          take_first = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (!scan_en) begin
          state_nxt = ST_IDLE;
          frame_err = 1'b1;
        end else if (last_bit) begin
          if (frame_ok) begin
            state_nxt = ST_VALID;
            load_pkt  = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
            frame_err = 1'b1;
          end
        end else begin
          take_bit = 1'b1;
        end
      end
      ST_VALID: begin
        if (pkt_ready) begin
          accept    = 1'b1;
          state_nxt = scan_en ? ST_WAIT_LOW : ST_IDLE;
        end
      end
      ST_WAIT_LOW: begin
        if (!scan_en) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Frame assembly, packet capture, sticky error and accept counter.
  always_ff @(posedge gpio_clk or negedge reset) begin
    if (!reset) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      pkt_data  <= '0;
      err       <= 1'b0;
      pkt_count <= '0;
    end else begin
      if (take_first) begin
        shreg   <= SH_W'(scan_bit);
        bit_cnt <= CNT_W'(1);
      end else if (take_bit) begin
        shreg   <= shift_in;
        bit_cnt <= bit_cnt + CNT_W'(1);
      end else if (load_pkt || frame_err) begin
        shreg   <= '0;
        bit_cnt <= '0;
      end
      if (load_pkt)  pkt_data  <= frame_word;
      if (frame_err) err       <= 1'b1;
      if (accept)    pkt_count <= pkt_count + 8'd1;
    end
  end

  assign pkt_valid = (state == ST_VALID);
  assign busy      = (state != ST_IDLE);

  openram_scan_out #(.OUT_W(OUT_W)) u_scan_out (
    .gpio_clk   (gpio_clk),
    .reset      (reset),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .out_bit    (out_bit),
    .out_active (out_active)
  );

endmodule

// File: doc/openram_scan_loader.md
OPENRAM_SCAN_LOADER -- requirements
Module: openram_scan_loader

Interface
REQ-001 Parameter PKT_W, default 112, SRAM command packet width in bits.
REQ-002 Parameter OUT_W, default 64, read-result width in bits, {rw data, ro data}.
REQ-003 gpio_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low: asserted at 0, released synchronously to gpio_clk.
REQ-005 scan_en  input  1  frame strobe; high while packet bits are presented.
REQ-006 scan_bit  input  1  serial packet data, MSB first, sampled while scan_en=1.
REQ-007 pkt_data  output  PKT_W  assembled packet to the test-chip control logic.
REQ-008 pkt_valid  output  1  pkt_data holds a complete packet.
REQ-009 pkt_ready  input  1  downstream accepts pkt_data.
REQ-010 rd_data  input  OUT_W  SRAM read result to return.
REQ-011 rd_valid  input  1  single-cycle pulse: capture rd_data.
REQ-012 out_bit  output  1  serial read result, MSB first.
REQ-013 out_active  output  1  out_bit carries valid data.
REQ-014 busy  output  1  input FSM not in IDLE.
REQ-015 err  output  1  sticky framing/parity error flag.
REQ-016 pkt_count  output  8  count of accepted packets.

Function
REQ-017 Input FSM states: IDLE, SHIFT, VALID, WAIT_LOW.
- IDLE->SHIFT when scan_en=1; the first bit is sampled on that edge.
REQ-018 SHIFT: each edge with scan_en=1 shifts scan_bit into the LSB of the shift register and increments a bit counter.
REQ-019 On the edge sampling bit PKT_W, the shift register is copied to pkt_data; pkt_valid=1 from the next cycle; state->VALID.
REQ-020 scan_en=0 in SHIFT before PKT_W bits -> short frame: err set, bits discarded, pkt_data unchanged, state->IDLE.
REQ-021 pkt_data stable while pkt_valid=1; handshake completes on an edge with pkt_valid=1 and pkt_ready=1; pkt_valid clears that edge.
REQ-022 After handshake: scan_en=0 -> IDLE; scan_en=1 -> WAIT_LOW; WAIT_LOW->IDLE when scan_en=0; scan_bit ignored in VALID and WAIT_LOW.
REQ-023 pkt_count increments by one per handshake, wraps 255->0.
REQ-024 busy=1 in every state except IDLE.
REQ-025 Output path is independent of the input FSM: rd_valid=1 loads rd_data into the output shift register and sets out_active=1 from the next cycle.
REQ-026 out_bit = register MSB; register shifts left one bit per cycle; out_active clears after exactly OUT_W bits have been presented.
REQ-027 rd_valid during an active shift-out restarts it with the new rd_data (latest wins); err unaffected.
REQ-028 err clears only on reset.

Reset
REQ-029 While reset=0: state IDLE, pkt_data=0, pkt_valid=0, out_bit=0, out_active=0, busy=0, err=0, pkt_count=0, counters and shift registers 0.
REQ-030 Reset mid-frame or mid-shift-out aborts the operation; no partial packet is ever presented.

Configuration
REQ-031 Macro SCAN_PARITY_EN defined: frame is PKT_W+1 bits, the final bit being even parity over all PKT_W+1 bits; mismatch sets err, discards the packet, state->IDLE, pkt_valid never asserted.
REQ-032 Macro undefined: frame is PKT_W bits, no parity checking; all other behaviour identical.

Structure
REQ-033 Shared package openram_pkg holds PKT_W/OUT_W defaults, the FSM state enum, and packet field offsets (sram select [111:108], port-0 and port-1 field positions).
REQ-034 One sub-module, openram_scan_out, implements the output serializer (REQ-025..027).

Verification
REQ-035 Shift 112-bit packet {4'd0,16'd1,32'd1,1'b0,1'b0,4'd15,16'd0,32'd0,1'b1,1'b1,4'd0}, pkt_ready=1 -> pkt_valid one cycle after bit 112, pkt_data equals packet, pkt_count=1.
REQ-036 pkt_ready=0 for 10 cycles after valid -> pkt_valid and pkt_data held constant; accepted on the first cycle pkt_ready=1.
REQ-037 scan_en dropped after 50 bits -> err=1, pkt_valid stays 0, busy=0 next cycle.
REQ-038 rd_valid with rd_data=64'h8000_0000_0000_0001 -> out_bit 1, then 62 zeros, then 1; out_active high exactly 64 cycles.
REQ-039 SCAN_PARITY_EN defined: correct parity -> packet accepted; flipped parity bit -> err=1, no pkt_valid.
REQ-040 reset asserted at bit 60 of a frame -> all outputs 0 immediately; subsequent full frame accepted normally.
